// File: rtl/cook_sequencer_pkg.sv
// Shared definitions for the microwave cook sequencer: FSM state encoding and
// the quick-start preset time.
package cook_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] QUICK_START_BCD = 16'h0030;
    localparam logic [15:0] ONE_SECOND_BCD  = 16'h0001;

endpackage

// File: rtl/bcd_time_dec.sv
// Combinational mm:ss BCD decrement by one second, plus zero and
// invalid-seconds-tens flags on the incoming value.
module bcd_time_dec (
    input  logic [15:0] time_in,
    output logic [15:0] time_dec,
    output logic        is_zero,
    output logic        s1_invalid
);

    logic [3:0] s0, s1, m0, m1;
    logic [3:0] d_s0, d_s1, d_m0, d_m1;

    assign s0 = time_in[3:0];
    assign s1 = time_in[7:4];
    assign m0 = time_in[11:8];
    assign m1 = time_in[15:12];

    // Borrow ripples s0 -> s1 -> m0 -> m1; seconds tens wrap to 5, not 9.
    always_comb begin
        d_s0 = s0 - 4'd1;
        d_s1 = s1;
        d_m0 = m0;
        d_m1 = m1;
        if (s0 == 4'd0) begin
            d_s0 = 4'd9;
            d_s1 = s1 - 4'd1;
            if (s1 == 4'd0) begin
                d_s1 = 4'd5;
                d_m0 = m0 - 4'd1;
                if (m0 == 4'd0) begin
                    d_m0 = 4'd9;
                    d_m1 = (m1 == 4'd0) ? 4'd9 : m1 - 4'd1;
                end
            end
        end
    end

    assign time_dec   = {d_m1, d_m0, d_s1, d_s0};
    assign is_zero    = (time_in == 16'h0000);
    assign s1_invalid = (s1 > 4'd5);

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook-cycle controller: keypad time entry, 1 s countdown, door and
// power-level gating of the magnetron, and the timed completion beep.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | no time entered, magnetron off
// ST_SET   | time being entered or held after a stop
// ST_COOK  | counting down, magnetron gated by door and duty
// ST_PAUSE | countdown frozen (door opened or stop pressed)
// ST_DONE  | countdown reached zero, beeping for BEEP_SECS
module cook_sequencer
    import cook_sequencer_pkg::*;
#(
    parameter int CLK_HZ    = 100,
    parameter int BEEP_SECS = 3,
    parameter int DUTY_SECS = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        startn,
    input  logic        stopn,
    input  logic        clearn,
    input  logic        door_closed,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic [3:0]  power_level,
    output logic [15:0] time_bcd,
    output logic        mag_on,
    output logic        cooking,
    output logic        done_beep,
    output logic [2:0]  state
);

    localparam int             PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PS_LAST    = PW'(CLK_HZ - 1);
    localparam logic [3:0]     DUTY_LAST  = 4'(DUTY_SECS - 1);
    localparam logic [7:0]     BEEP_LAST  = 8'(BEEP_SECS - 1);

    state_t        state_q, state_d;
    logic [15:0]   time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    duty_q, duty_d;
    logic [7:0]    beep_q, beep_d;
    logic          start_q, stop_q, clear_q;

    logic          ev_start, ev_stop, ev_clear, key_ok, tick;
    logic [15:0]   time_dec;
    logic          t_zero, s1_bad;

    bcd_time_dec u_dec (
        .time_in    (time_q),
        .time_dec   (time_dec),
        .is_zero    (t_zero),
        .s1_invalid (s1_bad)
    );

    // Buttons are active-low: an event is a high-to-low step against history.
    assign ev_start = start_q & ~startn;
    assign ev_stop  = stop_q  & ~stopn;
    assign ev_clear = clear_q & ~clearn;
    assign key_ok   = key_valid & (key_digit <= 4'd9);
    assign tick     = (presc_q == PS_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            time_q  <= 16'h0000;
            presc_q <= '0;
            duty_q  <= 4'd0;
            beep_q  <= 8'd0;
            start_q <= 1'b1;
            stop_q  <= 1'b1;
            clear_q <= 1'b1;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            presc_q <= presc_d;
            duty_q  <= duty_d;
            beep_q  <= beep_d;
            start_q <= startn;
            stop_q  <= stopn;
            clear_q <= clearn;
        end
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        duty_d  = duty_q;
        beep_d  = beep_q;
        case (state_q)
            ST_IDLE, ST_SET: begin
                if (ev_clear) begin
                    state_d = ST_IDLE;
                    time_d  = 16'h0000;
                end else if (ev_stop) begin
                    state_d = state_q;
                end else if (ev_start) begin
                    // A rejected start still consumes the cycle; a same-cycle key is dropped.
                    if (door_closed) begin
                        if (state_q == ST_IDLE && t_zero) begin
                            state_d = ST_COOK;
                            time_d  = QUICK_START_BCD;
                            presc_d = '0;
                            duty_d  = 4'd0;
                        end else if (!t_zero && !s1_bad) begin
                            state_d = ST_COOK;
                            presc_d = '0;
                            duty_d  = 4'd0;
                        end
                    end
                end else if (key_ok) begin
                    state_d = ST_SET;
                    time_d  = {time_q[11:0], key_digit};
                end
            end
            ST_COOK: begin
                if (ev_clear) begin
                    state_d = ST_IDLE;
                    time_d  = 16'h0000;
                end else if (ev_stop || !door_closed) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    presc_d = '0;
                    time_d  = time_dec;
                    duty_d  = (duty_q >= DUTY_LAST) ? 4'd0 : duty_q + 4'd1;
                    if (time_q == ONE_SECOND_BCD) begin
                        state_d = ST_DONE;
                        beep_d  = 8'd0;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (ev_clear) begin
                    state_d = ST_IDLE;
                    time_d  = 16'h0000;
                end else if (ev_stop) begin
                    state_d = ST_SET;
                end else if (ev_start && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (ev_clear || ev_stop || ev_start || !door_closed) begin
                    state_d = ST_IDLE;
                    time_d  = 16'h0000;
                end else if (tick) begin
                    presc_d = '0;
                    if (beep_q >= BEEP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        beep_d = beep_q + 8'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                time_d  = 16'h0000;
            end
        endcase
    end

    // Door is deliberately combinational here so opening it kills heat immediately.
    assign mag_on    = (state_q == ST_COOK) & door_closed & (duty_q < power_level);
    assign cooking   = (state_q == ST_COOK);
    assign done_beep = (state_q == ST_DONE);
    assign time_bcd  = time_q;
    assign state     = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Scoreboard bench for cook_sequencer at CLK_HZ=4: stimulus queues expected
// output snapshots, a negedge monitor pops and compares them.
module tb_cook_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
    logic        door_closed = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic [3:0]  power_level = 4'd10;
    logic [15:0] time_bcd;
    logic        mag_on, cooking, done_beep;
    logic [2:0]  state;

    localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_COOK = 3'd2,
                           S_PAUSE = 3'd3, S_DONE = 3'd4;

    typedef struct {
        string       name;
        logic [15:0] t;
        logic [2:0]  st;
        logic        mag;
        logic        cook;
        logic        beep;
    } exp_t;

    exp_t exp_q[$];
    logic chk_req = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cook_sequencer #(.CLK_HZ(4), .BEEP_SECS(3), .DUTY_SECS(10)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .power_level (power_level),
        .time_bcd    (time_bcd),
        .mag_on      (mag_on),
        .cooking     (cooking),
        .done_beep   (done_beep),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor: got a check request with no expected entry queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (time_bcd !== e.t || state !== e.st || mag_on !== e.mag ||
                    cooking !== e.cook || done_beep !== e.beep) begin
                    errors++;
                    $display("FAIL %s: got time=%h state=%0d mag=%b cook=%b beep=%b, want time=%h state=%0d mag=%b cook=%b beep=%b",
                             e.name, time_bcd, state, mag_on, cooking, done_beep,
                             e.t, e.st, e.mag, e.cook, e.beep);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [15:0] t, input logic [2:0] st,
                              input logic mag, input logic cook, input logic beep);
        exp_t e;
        e.name = name; e.t = t; e.st = st; e.mag = mag; e.cook = cook; e.beep = beep;
        exp_q.push_back(e);
        chk_req = 1'b1;
        @(negedge clk);
        #1 chk_req = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick(1);
        key_valid = 1'b0;
    endtask

    task automatic press_start();
        startn = 1'b0; tick(1); startn = 1'b1;
    endtask

    task automatic press_stop();
        stopn = 1'b0; tick(1); stopn = 1'b1;
    endtask

    task automatic press_clear();
        clearn = 1'b0; tick(1); clearn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        expect_out("reset", 16'h0000, S_IDLE, 0, 0, 0);
        rstn = 1'b1;
        tick(2);

        // keypad entry, start, first second
        key(4'd1); key(4'd2); key(4'd5);
        expect_out("keys_125", 16'h0125, S_SET, 0, 0, 0);
        press_start();
        expect_out("start_set", 16'h0125, S_COOK, 1, 1, 0);
        tick(3);
        expect_out("before_tick", 16'h0125, S_COOK, 1, 1, 0);
        tick(1);
        expect_out("first_tick", 16'h0124, S_COOK, 1, 1, 0);
        press_clear();
        expect_out("clear_cook", 16'h0000, S_IDLE, 0, 0, 0);

        // count to zero, beep window
        key(4'd0); key(4'd2);
        expect_out("keys_02", 16'h0002, S_SET, 0, 0, 0);
        press_start();
        tick(7);
        expect_out("last_cook_clk", 16'h0001, S_COOK, 1, 1, 0);
        tick(1);
        expect_out("enter_done", 16'h0000, S_DONE, 0, 0, 1);
        tick(11);
        expect_out("beep_last", 16'h0000, S_DONE, 0, 0, 1);
        tick(1);
        expect_out("beep_over", 16'h0000, S_IDLE, 0, 0, 0);

        // power-level duty
        power_level = 4'd3;
        key(4'd2); key(4'd0);
        press_start();
        expect_out("duty_sec0", 16'h0020, S_COOK, 1, 1, 0);
        tick(11);
        expect_out("duty_sec2", 16'h0018, S_COOK, 1, 1, 0);
        tick(1);
        expect_out("duty_sec3", 16'h0017, S_COOK, 0, 1, 0);
        tick(27);
        expect_out("duty_sec9", 16'h0011, S_COOK, 0, 1, 0);
        tick(1);
        expect_out("duty_wrap", 16'h0010, S_COOK, 1, 1, 0);
        power_level = 4'd0;
        expect_out("power_zero", 16'h0010, S_COOK, 0, 1, 0);
        power_level = 4'd10;
        press_clear();

        // door open pause and resume
        key(4'd1); key(4'd0);
        press_start();
        tick(5);
        door_closed = 1'b0;
        expect_out("door_same_cyc", 16'h0009, S_COOK, 0, 1, 0);
        tick(1);
        expect_out("door_pause", 16'h0009, S_PAUSE, 0, 0, 0);
        tick(8);
        expect_out("pause_frozen", 16'h0009, S_PAUSE, 0, 0, 0);
        door_closed = 1'b1;
        tick(1);
        press_start();
        expect_out("resume", 16'h0009, S_COOK, 1, 1, 0);
        tick(2);
        expect_out("resume_hold", 16'h0009, S_COOK, 1, 1, 0);
        tick(1);
        expect_out("resume_tick", 16'h0008, S_COOK, 1, 1, 0);
        press_stop();
        tick(1);
        press_stop();
        expect_out("stop_to_set", 16'h0008, S_SET, 0, 0, 0);
        tick(1);
        press_clear();

        // quick start, invalid seconds, minute borrow
        press_start();
        expect_out("quick_start", 16'h0030, S_COOK, 1, 1, 0);
        press_clear();
        key(4'd1); key(4'd7); key(4'd0);
        press_start();
        expect_out("start_s1_bad", 16'h0170, S_SET, 0, 0, 0);
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        press_start();
        tick(4);
        expect_out("borrow_1000", 16'h0959, S_COOK, 1, 1, 0);
        press_clear();

        // clear+stop together, async reset mid-cook
        key(4'd2); key(4'd0);
        press_start();
        tick(2);
        clearn = 1'b0; stopn = 1'b0;
        tick(1);
        clearn = 1'b1; stopn = 1'b1;
        expect_out("clear_stop", 16'h0000, S_IDLE, 0, 0, 0);
        tick(1);
        press_start();
        tick(2);
        rstn = 1'b0;
        expect_out("async_reset", 16'h0000, S_IDLE, 0, 0, 0);
        tick(2);
        rstn = 1'b1;
        tick(2);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
